// File: rtl/tv80_bus_dma.sv
// Memory-to-memory DMA engine: an I/O-port responder for the CPU, and a second
// bus master that copies LEN bytes from SRC to DST with Z80-style memory cycles.
module tv80_bus_dma #(
  parameter logic [7:0] IO_BASE = 8'h10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        doe,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] dma_A,
  output logic [7:0]  dma_do,
  input  logic [7:0]  dma_di,
  output logic        dma_mreq_n,
  output logic        dma_rd_n,
  output logic        dma_wr_n,
  output logic        dma_oe,
  input  logic        dma_wait_n,
  output logic        int_n,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD1, S_RD2, S_WR1, S_WR2, S_WR3, S_REL
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_len;
  logic [7:0]  r_hold;
  logic        r_ie;
  logic        r_done;
  logic        r_io_wr_d;

  logic w_sel;
  logic w_io_wr;
  logic w_wr_stb;
  logic w_busy;
  logic w_start;
  logic w_unused_addr;

  assign w_unused_addr = ^addr[15:8];
  assign w_sel    = (addr[7:3] == IO_BASE[7:3]);
  assign w_io_wr  = w_sel & ~iorq_n & ~wr_n & m1_n;
  assign w_wr_stb = w_io_wr & ~r_io_wr_d;
  assign w_busy   = (r_state != S_IDLE);
  assign w_start  = w_wr_stb & (addr[2:0] == 3'd6) & wr_data[0];
  assign doe      = w_sel & ~iorq_n & ~rd_n & m1_n;
  assign int_n    = ~(r_done & r_ie);
  assign dbg_state = r_state;

  always_comb begin
    rd_data = 8'h00;
    case (addr[2:0])
      3'd0: rd_data = r_src[7:0];
      3'd1: rd_data = r_src[15:8];
      3'd2: rd_data = r_dst[7:0];
      3'd3: rd_data = r_dst[15:8];
      3'd4: rd_data = r_len[7:0];
      3'd5: rd_data = r_len[15:8];
      3'd6: rd_data = {6'b0, r_ie, 1'b0};
      3'd7: rd_data = {6'b0, r_done, w_busy};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Bus handshake: busrq_n stays low from REQ to WR3; the bus is ours only
  // once busak_n is sampled low, and is handed back when busak_n returns high.
  always_comb begin
    w_next     = r_state;
    busrq_n    = 1'b1;
    dma_oe     = 1'b0;
    dma_A      = 16'h0000;
    dma_do     = 8'h00;
    dma_mreq_n = 1'b1;
    dma_rd_n   = 1'b1;
    dma_wr_n   = 1'b1;
    case (r_state)
      S_IDLE: if (w_start && r_len != 16'h0000) w_next = S_REQ;
      S_REQ: begin
        busrq_n = 1'b0;
        if (!busak_n) w_next = S_RD1;
      end
      S_RD1, S_RD2: begin
        busrq_n    = 1'b0;
        dma_oe     = 1'b1;
        dma_A      = r_src;
        dma_mreq_n = 1'b0;
        dma_rd_n   = 1'b0;
        if (r_state == S_RD1)  w_next = S_RD2;
        else if (dma_wait_n)   w_next = S_WR1;
      end
      S_WR1, S_WR2, S_WR3: begin
        busrq_n    = 1'b0;
        dma_oe     = 1'b1;
        dma_A      = r_dst;
        dma_do     = r_hold;
        dma_mreq_n = (r_state == S_WR3);
        dma_wr_n   = (r_state != S_WR2);
        if (r_state == S_WR1)      w_next = S_WR2;
        else if (r_state == S_WR3) w_next = (r_len == 16'h0001) ? S_REL : S_RD1;
        else if (dma_wait_n)       w_next = S_WR3;
      end
      S_REL: if (busak_n) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src     <= 16'h0000;
      r_dst     <= 16'h0000;
      r_len     <= 16'h0000;
      r_hold    <= 8'h00;
      r_ie      <= 1'b0;
      r_done    <= 1'b0;
      r_io_wr_d <= 1'b0;
    end else begin
      r_io_wr_d <= w_io_wr;
      if (r_state == S_RD2 && dma_wait_n) r_hold <= dma_di;
      if (r_state == S_WR3) begin
        r_src <= r_src + 16'd1;
        r_dst <= r_dst + 16'd1;
        r_len <= r_len - 16'd1;
      end
      // Address/length registers are frozen while a copy is running.
      if (w_wr_stb) begin
        case (addr[2:0])
          3'd0: if (!w_busy) r_src[7:0]  <= wr_data;
          3'd1: if (!w_busy) r_src[15:8] <= wr_data;
          3'd2: if (!w_busy) r_dst[7:0]  <= wr_data;
          3'd3: if (!w_busy) r_dst[15:8] <= wr_data;
          3'd4: if (!w_busy) r_len[7:0]  <= wr_data;
          3'd5: if (!w_busy) r_len[15:8] <= wr_data;
          3'd6: begin
            r_ie <= wr_data[1];
            if (wr_data[7]) r_done <= 1'b0;
            if (wr_data[0] && !w_busy && r_len == 16'h0000) r_done <= 1'b1;
          end
          default: ;
        endcase
      end
      if (r_state == S_REL && busak_n) r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tv80_bus_dma.sv
// Directed bench for tv80_bus_dma: CPU I/O port model, grant model and a byte RAM.
module tb_tv80_bus_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  rd_data;
  logic        doe;
  logic        busrq_n;
  logic        busak_n = 1'b1;
  logic [15:0] dma_A;
  logic [7:0]  dma_do;
  logic [7:0]  dma_di;
  logic        dma_mreq_n, dma_rd_n, dma_wr_n, dma_oe;
  logic        dma_wait_n = 1'b1;
  logic        int_n;
  logic [2:0]  dbg_state;

  logic [7:0]  ram [0:65535];
  logic        di_ovr_en = 1'b0;
  logic [7:0]  di_ovr_val = 8'h00;
  logic        ack_block = 1'b0;
  logic        mon_clr = 1'b0;

  int total = 0;
  int bad = 0;

  int          oe_cnt, cur_clks, wr_cnt, rq_cnt, prot_bad;
  logic        prev_rd, prev_wr;
  logic [15:0] rd_addr_q[$];
  int          byte_q[$];
  logic [7:0]  rv;

  tv80_bus_dma #(.IO_BASE(8'h10)) dut (
    .clk(clk), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .m1_n(m1_n), .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .doe(doe),
    .busrq_n(busrq_n), .busak_n(busak_n), .dma_A(dma_A), .dma_do(dma_do),
    .dma_di(dma_di), .dma_mreq_n(dma_mreq_n), .dma_rd_n(dma_rd_n),
    .dma_wr_n(dma_wr_n), .dma_oe(dma_oe), .dma_wait_n(dma_wait_n),
    .int_n(int_n), .dbg_state(dbg_state)
  );

  // ---------------- clock / bus models ----------------
  always #5 clk = ~clk;

  assign dma_di = di_ovr_en ? di_ovr_val : ram[dma_A];

  always @(negedge clk) begin
    if (dma_oe && !dma_mreq_n && !dma_wr_n) ram[dma_A] = dma_do;
  end

  // CPU grants one clock after the request moves, unless held off.
  always @(posedge clk) begin
    #2;
    busak_n = ack_block ? 1'b1 : busrq_n;
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      oe_cnt = 0; cur_clks = 0; wr_cnt = 0; rq_cnt = 0; prot_bad = 0;
      prev_rd = 1'b0; prev_wr = 1'b0;
      rd_addr_q.delete(); byte_q.delete();
    end else begin
      if (!busrq_n) rq_cnt++;
      if (busak_n && (dma_oe || !dma_mreq_n || !dma_rd_n || !dma_wr_n)) prot_bad++;
      if (dma_oe) begin oe_cnt++; cur_clks++; end
      if (dma_oe && !dma_mreq_n && !dma_rd_n && !prev_rd) rd_addr_q.push_back(dma_A);
      if (dma_oe && !dma_wr_n && !prev_wr) wr_cnt++;
      if (dma_oe && dma_mreq_n) begin byte_q.push_back(cur_clks); cur_clks = 0; end
      prev_rd = dma_oe && !dma_mreq_n && !dma_rd_n;
      prev_wr = dma_oe && !dma_wr_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon;
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    addr = {8'h00, a}; wr_data = d; iorq_n = 1'b0; wr_n = 1'b0;
    tick;
    iorq_n = 1'b1; wr_n = 1'b1;
    tick;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    addr = {8'h00, a}; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = rd_data;
    iorq_n = 1'b1; rd_n = 1'b1;
    tick;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_read(a, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n);
    io_write(8'h10, s[7:0]); io_write(8'h11, s[15:8]);
    io_write(8'h12, t[7:0]); io_write(8'h13, t[15:8]);
    io_write(8'h14, n[7:0]); io_write(8'h15, n[15:8]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (dbg_state != 3'd0 && n < budget) begin tick; n++; end
    check(tag, {31'h0, dbg_state == 3'd0}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    mon_clr = 1'b1;
    #1;
    check("rst_outs", {busrq_n, dma_oe, dma_mreq_n, dma_rd_n, dma_wr_n, int_n},
          6'b101111);
    check("rst_addr", {dma_A, dma_do}, 24'h0);
    tick; tick;
    reset_n = 1'b1;
    tick;
    mon_clr = 1'b0;
    check_reg("rst_status", 8'h17, 8'h00);
    check_reg("rst_len", 8'h14, 8'h00);

    // Basic 4-byte copy with interrupt enabled.
    ram[16'h8000] = 8'h11; ram[16'h8001] = 8'h22;
    ram[16'h8002] = 8'h33; ram[16'h8003] = 8'h44;
    setup(16'h8000, 16'h8100, 16'h0004);
    clr_mon;
    io_write(8'h16, 8'h03);
    wait_idle("t1_idle", 300);
    check("t1_oe_clks", oe_cnt, 20);
    check("t1_nbytes", byte_q.size(), 4);
    for (int i = 0; i < 4 && i < byte_q.size(); i++) check("t1_byte_clks", byte_q[i], 5);
    check("t1_ram0", ram[16'h8100], 8'h11);
    check("t1_ram1", ram[16'h8101], 8'h22);
    check("t1_ram2", ram[16'h8102], 8'h33);
    check("t1_ram3", ram[16'h8103], 8'h44);
    check("t1_prot", prot_bad, 0);
    check_reg("t1_status", 8'h17, 8'h02);
    check_reg("t1_ctrl", 8'h16, 8'h02);
    check_reg("t1_src_lo", 8'h10, 8'h04);
    check_reg("t1_dst_hi", 8'h13, 8'h81);
    check("t1_int", int_n, 1'b0);
    io_write(8'h16, 8'h80);
    check("t1_int_clr", int_n, 1'b1);
    check_reg("t1_status_clr", 8'h17, 8'h00);

    // doe decode and interrupt-acknowledge cycles.
    addr = 16'h0010; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    #1 check("doe_m1", doe, 1'b0);
    m1_n = 1'b1;
    #1 check("doe_sel", doe, 1'b1);
    addr = 16'h0020;
    #1 check("doe_unsel", doe, 1'b0);
    iorq_n = 1'b1; rd_n = 1'b1;
    tick;
    m1_n = 1'b0;
    io_write(8'h10, 8'hEE);
    m1_n = 1'b1;
    check_reg("m1_wr_ignored", 8'h10, 8'h04);

    // Zero length: DONE at once, bus never requested.
    clr_mon;
    io_write(8'h16, 8'h03);
    check("t2_int", int_n, 1'b0);
    check("t2_rq", rq_cnt, 0);
    check("t2_oe", oe_cnt, 0);
    check_reg("t2_status", 8'h17, 8'h02);
    io_write(8'h16, 8'h80);

    // Grant held off; busy-time register writes must be dropped.
    ram[16'h9000] = 8'hA1; ram[16'h9001] = 8'hB2;
    setup(16'h9000, 16'h9100, 16'h0002);
    clr_mon;
    ack_block = 1'b1;
    io_write(8'h16, 8'h01);
    for (int i = 0; i < 10; i++) begin
      check("t3_blocked", {dma_oe, dma_mreq_n, dma_rd_n, dma_wr_n, busrq_n}, 5'b01110);
      tick;
    end
    check_reg("t3_busy", 8'h17, 8'h01);
    io_write(8'h14, 8'h09);
    io_write(8'h10, 8'h55);
    ack_block = 1'b0;
    wait_idle("t3_idle", 200);
    check("t3_oe_clks", oe_cnt, 10);
    check("t3_ram0", ram[16'h9100], 8'hA1);
    check("t3_ram1", ram[16'h9101], 8'hB2);
    check("t3_prot", prot_bad, 0);
    check_reg("t3_src_lo", 8'h10, 8'h02);
    check_reg("t3_len_lo", 8'h14, 8'h00);
    check_reg("t3_status", 8'h17, 8'h02);
    check("t3_int_off", int_n, 1'b1);
    io_write(8'h16, 8'h80);

    // Source address wrap.
    ram[16'hFFFE] = 8'h01; ram[16'hFFFF] = 8'h02; ram[16'h0000] = 8'h03;
    setup(16'hFFFE, 16'hA000, 16'h0003);
    clr_mon;
    io_write(8'h16, 8'h01);
    wait_idle("t4_idle", 200);
    check("t4_nrd", rd_addr_q.size(), 3);
    if (rd_addr_q.size() == 3) begin
      check("t4_rd0", rd_addr_q[0], 16'hFFFE);
      check("t4_rd1", rd_addr_q[1], 16'hFFFF);
      check("t4_rd2", rd_addr_q[2], 16'h0000);
    end
    check_reg("t4_src_lo", 8'h10, 8'h01);
    check_reg("t4_src_hi", 8'h11, 8'h00);
    check_reg("t4_len_hi", 8'h15, 8'h00);
    check("t4_ram2", ram[16'hA002], 8'h03);
    io_write(8'h16, 8'h80);

    // Three wait clocks in the second byte's read; data taken at release.
    ram[16'hB000] = 8'hC1; ram[16'hB001] = 8'hC2; ram[16'hB002] = 8'hC3;
    setup(16'hB000, 16'hB100, 16'h0003);
    clr_mon;
    io_write(8'h16, 8'h01);
    for (int n = 0; n < 100 && rd_addr_q.size() < 2; n++) tick;
    check("t5_rd2_seen", rd_addr_q.size(), 2);
    dma_wait_n = 1'b0; di_ovr_en = 1'b1; di_ovr_val = 8'hAA;
    tick; tick; tick; tick;
    dma_wait_n = 1'b1; di_ovr_val = 8'h5C;
    tick;
    di_ovr_en = 1'b0;
    wait_idle("t5_idle", 200);
    check("t5_nbytes", byte_q.size(), 3);
    if (byte_q.size() == 3) begin
      check("t5_b0", byte_q[0], 5);
      check("t5_b1", byte_q[1], 8);
      check("t5_b2", byte_q[2], 5);
    end
    check("t5_ram0", ram[16'hB100], 8'hC1);
    check("t5_ram1", ram[16'hB101], 8'h5C);
    check("t5_ram2", ram[16'hB102], 8'hC3);
    io_write(8'h16, 8'h80);

    // Asynchronous reset during the second byte's write strobe.
    setup(16'hC000, 16'hC100, 16'h0004);
    clr_mon;
    io_write(8'h16, 8'h03);
    for (int n = 0; n < 100 && wr_cnt < 2; n++) tick;
    check("t6_wr2_seen", wr_cnt, 2);
    check("t6_in_wr", dma_wr_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_outs", {busrq_n, dma_oe, dma_wr_n, dma_mreq_n}, 4'b1011);
    tick; tick;
    reset_n = 1'b1;
    tick;
    for (int r = 0; r < 8; r++) begin
      io_read(8'h10 + 8'(r), rv);
      check("t6_reg_zero", {24'h0, rv}, 32'h0);
    end
    check("t6_int", int_n, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
